// File: rtl/datapath_pkg.sv
// Shared constants for the 16-bit datapath routing blocks.
package datapath_pkg;

   // Default data and counter widths for the datapath.
   localparam int DP_WIDTH = 16;
   localparam int DP_CNT_W = 16;

   // Lane select encodings carried on the S input.
   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage : datapath_pkg

// File: rtl/route16_1to2_out_slot.sv
// One destination lane: a single-entry valid/ready output register with a
// wrapping count of completed handshakes.
module out_slot
   import datapath_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH,
   parameter int CNT_W = DP_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,     // write data_i into the slot this cycle
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,    // destination consumes the held word
   input  logic             cnt_clr_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             free_o,     // slot can take a word this cycle
   output logic [CNT_W-1:0] cnt_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deliver;

   // A handshake completes whenever a held word meets a ready destination.
   assign deliver = valid_q & ready_i;
   // A draining slot counts as free, giving full throughput with ready held high.
   assign free_o  = ~valid_q | ready_i;

   // Next-state: drain, then refill (refill wins), counter clear beats increment.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (deliver) begin
         valid_d = 1'b0;
         cnt_d   = cnt_q + CNT_W'(1);
      end
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
      if (cnt_clr_i) begin
         cnt_d = '0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n_i) begin
         // NOTE: the data register is reset too, because its reset value is visible on the port.
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign cnt_o   = cnt_q;

endmodule : out_slot

// File: rtl/route16_1to2.sv
// Registered 1:2 demultiplexer: steers a source word to one of two
// independently handshaked output lanes and counts deliveries per lane.
module route16_1to2
   import datapath_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH,
   parameter int CNT_W = DP_CNT_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] I,
   input  logic             S,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] O0,
   output logic             O0_VALID,
   input  logic             O0_READY,
   output logic [WIDTH-1:0] O1,
   output logic             O1_VALID,
   input  logic             O1_READY,
   input  logic             CNT_CLR,
   output logic [CNT_W-1:0] CNT0,
   output logic [CNT_W-1:0] CNT1
);

   logic free0, free1;
   logic in_ready;
   logic accept;
   logic load0, load1;

   // Ready reflects only the selected lane's capacity and reset, never IN_VALID,
   // so the source cannot form a combinational loop through it.
   always_comb begin
      in_ready = 1'b0;
      if (RST_N) begin
         in_ready = (S == LANE1) ? free1 : free0;
      end
   end

   // Select decode: the accepted word loads only the addressed lane.
   always_comb begin
      accept = IN_VALID & in_ready;
      load0  = 1'b0;
      load1  = 1'b0;
      if (accept) begin
         load0 = (S == LANE0);
         load1 = (S == LANE1);
      end
   end

   assign IN_READY = in_ready;

   out_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_slot0 (
      .clk_i    (CLK),
      .rst_n_i  (RST_N),
      .load_i   (load0),
      .data_i   (I),
      .ready_i  (O0_READY),
      .cnt_clr_i(CNT_CLR),
      .data_o   (O0),
      .valid_o  (O0_VALID),
      .free_o   (free0),
      .cnt_o    (CNT0)
   );

   out_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_slot1 (
      .clk_i    (CLK),
      .rst_n_i  (RST_N),
      .load_i   (load1),
      .data_i   (I),
      .ready_i  (O1_READY),
      .cnt_clr_i(CNT_CLR),
      .data_o   (O1),
      .valid_o  (O1_VALID),
      .free_o   (free1),
      .cnt_o    (CNT1)
   );

endmodule : route16_1to2

// File: tb/tb_route16_1to2.sv
// Self-checking bench for route16_1to2: directed scenarios plus random traffic,
// compared every cycle against a per-lane reference model.
module tb_route16_1to2;

   logic        CLK;
   logic        RST_N;
   logic [15:0] I;
   logic        S;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] O0;
   logic        O0_VALID;
   logic        O0_READY;
   logic [15:0] O1;
   logic        O1_VALID;
   logic        O1_READY;
   logic        CNT_CLR;
   logic [15:0] CNT0;
   logic [15:0] CNT1;

   int checks = 0;
   int errors = 0;

   // Reference model: each lane holds at most one word; counters are integers mod 2^16.
   bit          m_valid [2];
   logic [15:0] m_data  [2];
   int          m_cnt   [2];

   route16_1to2 dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .I       (I),
      .S       (S),
      .IN_VALID(IN_VALID),
      .IN_READY(IN_READY),
      .O0      (O0),
      .O0_VALID(O0_VALID),
      .O0_READY(O0_READY),
      .O1      (O1),
      .O1_VALID(O1_VALID),
      .O1_READY(O1_READY),
      .CNT_CLR (CNT_CLR),
      .CNT0    (CNT0),
      .CNT1    (CNT1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   task check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check IN_READY mid-cycle, advance model, check outputs after the edge.
   task cycle(input logic rst, input logic iv, input logic sel, input logic [15:0] d,
              input logic r0, input logic r1, input logic clr);
      logic exp_rdy;
      logic acc;
      logic rdy [2];
      RST_N    = rst;
      IN_VALID = iv;
      S        = sel;
      I        = d;
      O0_READY = r0;
      O1_READY = r1;
      CNT_CLR  = clr;
      @(negedge CLK);
      rdy[0]  = r0;
      rdy[1]  = r1;
      exp_rdy = rst && (!m_valid[sel] || rdy[sel]);
      check("in_ready", 16'(IN_READY), 16'(exp_rdy));
      acc = iv && exp_rdy;
      for (int n = 0; n < 2; n++) begin
         if (!rst) begin
            m_valid[n] = 1'b0;
            m_data[n]  = 16'h0000;
            m_cnt[n]   = 0;
         end else begin
            if (clr) m_cnt[n] = 0;
            else if (m_valid[n] && rdy[n]) m_cnt[n] = (m_cnt[n] + 1) % 65536;
            m_valid[n] = (m_valid[n] && !rdy[n]) || (acc && int'(sel) == n);
            if (acc && int'(sel) == n) m_data[n] = d;
         end
      end
      @(posedge CLK);
      #1;
      check("o0_valid", 16'(O0_VALID), 16'(m_valid[0]));
      check("o0",       O0,            m_data[0]);
      check("o1_valid", 16'(O1_VALID), 16'(m_valid[1]));
      check("o1",       O1,            m_data[1]);
      check("cnt0",     CNT0,          16'(m_cnt[0]));
      check("cnt1",     CNT1,          16'(m_cnt[1]));
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         m_valid[n] = 1'b0;
         m_data[n]  = 16'h0000;
         m_cnt[n]   = 0;
      end

      // Reset held two cycles while a word is offered.
      cycle(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      check("rst_o0_valid", 16'(O0_VALID), 16'h0000);
      check("rst_cnt0", CNT0, 16'h0000);
      // Nothing appears after release without an accept.
      cycle(1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      check("idle_o0_valid", 16'(O0_VALID), 16'h0000);
      check("idle_o1_valid", 16'(O1_VALID), 16'h0000);

      // Basic route to lane 0, then delivery.
      cycle(1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0);
      check("basic_o0", O0, 16'h1234);
      check("basic_o0_valid", 16'(O0_VALID), 16'h0001);
      check("basic_o1_valid", 16'(O1_VALID), 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("basic_cnt0", CNT0, 16'h0001);
      check("basic_o0_hold", O0, 16'h1234);

      // Stall isolation: lane 1 full and stalled, lane 0 still accepts.
      cycle(1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
      check("stall_o1", O1, 16'hAAAA);
      cycle(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
      check("stall_o1_kept", O1, 16'hAAAA);
      cycle(1'b1, 1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b0, 1'b0);
      check("stall_o0_new", O0, 16'h0F0F);
      check("stall_o1_still", O1, 16'hAAAA);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

      // Back-to-back stream on lane 1 from cleared counters.
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 1'b1, 1'b1, 16'(k), 1'b1, 1'b1, 1'b0);
         check("b2b_o1", O1, 16'(k));
         check("b2b_o1_valid", 16'(O1_VALID), 16'h0001);
      end
      cycle(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("b2b_cnt1", CNT1, 16'h0008);

      // Counter wrap on lane 0: 65535 deliveries, then one more.
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 65535; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b1, 1'b1, 1'b0);
      end
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("wrap_cnt0_max", CNT0, 16'hFFFF);
      cycle(1'b1, 1'b1, 1'b0, 16'h4242, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("wrap_cnt0_zero", CNT0, 16'h0000);
      // Clear coinciding with a delivery leaves zero.
      cycle(1'b1, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1, 1'b0);
      check("clr_pre_cnt0", CNT0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("clr_pre2_cnt0", CNT0, 16'h0001);
      cycle(1'b1, 1'b1, 1'b0, 16'h9998, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      check("clr_cnt0", CNT0, 16'h0000);
      check("clr_o0_valid", 16'(O0_VALID), 16'h0000);

      // Random traffic on both lanes with occasional clears.
      for (int k = 0; k < 400; k++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 31) == 0));
      end

      // Reset in the middle of a stall discards the held word.
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 16'h7777, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("mid_o0", O0, 16'h7777);
      check("mid_o0_valid", 16'(O0_VALID), 16'h0001);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("mid_rst_o0_valid", 16'(O0_VALID), 16'h0000);
      check("mid_rst_o0", O0, 16'h0000);
      check("mid_rst_cnt0", CNT0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_route16_1to2

// File: doc/route16_1to2.md
Name: route16_1to2

Overview:
- Registered 1:2 demultiplexer for the 16-bit datapath. It takes one source word and steers it to one of two destinations selected by S, for example ALU result to the register-file write port or to the memory write buffer.
- Each destination lane has a one-entry output register with valid/ready handshake, so a stalled destination never blocks the other lane's registered data.
- Per-lane 16-bit transfer counters support debug and performance visibility.

Parameters:
- WIDTH, 16, data width of I, O0, O1.
- CNT_W, 16, width of per-lane transfer counters.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous reset, active-low, sampled on rising CLK.
- I  input  WIDTH  source data word.
- S  input  1  destination select: 0 routes to lane 0, 1 routes to lane 1.
- IN_VALID  input  1  source presents a valid word on I/S.
- IN_READY  output  1  block accepts the word this cycle.
- O0  output  WIDTH  lane 0 data (registered).
- O0_VALID  output  1  lane 0 holds a word.
- O0_READY  input  1  lane 0 destination consumes the word.
- O1  output  WIDTH  lane 1 data (registered).
- O1_VALID  output  1  lane 1 holds a word.
- O1_READY  input  1  lane 1 destination consumes the word.
- CNT_CLR  input  1  synchronous clear of both counters.
- CNT0  output  CNT_W  words delivered on lane 0 (handshakes completed).
- CNT1  output  CNT_W  words delivered on lane 1.

Behaviour:
- Reset (RST_N=0 at a rising edge): O0, O1 = 0; O0_VALID, O1_VALID = 0; CNT0, CNT1 = 0.
- Reset mid-transfer discards held words with no delivery. IN_READY is forced 0 while RST_N=0.
- Lane n is free when On_VALID=0, or when On_VALID=1 and On_READY=1 (draining this cycle).
- IN_READY is combinational: lane S is free, and RST_N=1. It depends only on S, lane state and On_READY, never on IN_VALID.
- Accept occurs when IN_VALID and IN_READY. On the next edge: On <= I and On_VALID <= 1 for n = S. The other lane is untouched.
- Latency is 1 cycle from accept to On_VALID=1. Full throughput is 1 word/cycle per lane when On_READY is held high.
- Delivery occurs when On_VALID and On_READY. On the next edge On_VALID <= 0, unless the same lane accepts a new word in that cycle, in which case On_VALID stays 1 and On is replaced.
- On holds its value while On_VALID=1 and On_READY=0 (stall). After delivery On retains its last value; it is not cleared.
- Lanes are independent. Ordering is guaranteed only within a lane, never across lanes.
- IN_VALID with S targeting a stalled full lane gives IN_READY=0. The source must hold I/S/IN_VALID until accepted; this is a source obligation and is not checked.
- Counters: CNTn increments by 1 on each lane-n delivery and wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- CNT_CLR has priority over increment: if clear and delivery occur in the same cycle, the result is 0.
- S is sampled only when IN_VALID=1; S is don't-care otherwise.

Decomposition:
- Shared package datapath_pkg: WIDTH default constant and lane-index constants LANE0=1'b0, LANE1=1'b1.
- One sub-module, out_slot: a single-entry valid/ready register plus its CNT_W counter. It is instantiated twice, once per lane.
- Top level holds only the select decode and IN_READY logic.

Test Plan:
- Reset: drive RST_N=0 for 2 cycles with IN_VALID=1, I=0xBEEF -> IN_READY=0, O0_VALID=O1_VALID=0, CNT0=CNT1=0. No word appears after release until a new accept.
- Basic route: I=0x1234, S=0, IN_VALID=1, O0_READY=1 for 1 cycle -> next cycle O0=0x1234, O0_VALID=1, O1_VALID=0. One cycle later CNT0=1.
- Stall isolation: fill lane 1 with 0xAAAA, hold O1_READY=0. Then send I=0x5555, S=1 -> IN_READY=0 and O1 stays 0xAAAA. Send I=0x0F0F, S=0 -> accepted, O0=0x0F0F next cycle.
- Back-to-back: stream 0x0001..0x0008 with S=1 and O1_READY=1 -> 8 consecutive O1_VALID cycles in order, IN_READY=1 throughout, CNT1=8.
- Counter wrap/clear: preload CNT0 to 0xFFFF via 65535 deliveries (or a force in the bench), deliver one more -> CNT0=0x0000. Assert CNT_CLR in the same cycle as a delivery -> CNT0=0.
- Reset mid-stall: lane 0 holding 0x7777 with O0_READY=0, apply RST_N=0 one cycle -> O0_VALID=0, O0=0, CNT0=0.
